// File: rtl/uart_mem_dump_tx.sv
// uart_mem_dump_tx: reads a range of memory words and sends each as 4 bytes over UART, 8N1, LSB first
module uart_mem_dump_tx #(
   parameter int CLKS_PER_BIT = 78,
   parameter int ADDR_W       = 14,
   parameter int CNT_W        = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_adr,
   input  logic [CNT_W-1:0]  word_cnt,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_adr_o,
   input  logic [31:0]       mem_dat_i,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, STOP, DONE} state_t;
   state_t            state, state_n;
   logic [ADDR_W-1:0] adr_n;
   logic [CNT_W-1:0]  left, left_n;
   logic [31:0]       sh, sh_n;
   logic [1:0]        byte_idx, byte_n;
   logic [2:0]        bit_idx, bit_n;
   logic [BW-1:0]     baud, baud_n;
   logic              tick;
   assign tick     = baud == BAUD_MAX;
   assign mem_rd_o = state == READ;
   assign busy_o   = state != IDLE;
   assign done_o   = state == DONE;
   always_comb begin
      state_n = state;
      adr_n   = mem_adr_o;
      left_n  = left;
      sh_n    = sh;
      byte_n  = byte_idx;
      bit_n   = bit_idx;
      baud_n  = (state inside {START, DATA, STOP}) && !tick ? baud + 1'b1 : '0;
      case (state)
         IDLE: if (start) begin
            adr_n   = start_adr;
            left_n  = word_cnt;
            state_n = word_cnt == '0 ? DONE : READ;
         end
         READ: state_n = LATCH;
         LATCH: begin
            sh_n    = mem_dat_i;
            byte_n  = '0;
            state_n = START;
         end
         START: if (tick) begin
            bit_n   = '0;
            state_n = DATA;
         end
         // The word is shifted right per bit, so sh[0] is always the next bit on the line
         DATA: if (tick) begin
            sh_n    = {1'b0, sh[31:1]};
            bit_n   = bit_idx + 1'b1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
         end
         STOP: if (tick) begin
            if (byte_idx != 2'd3) begin
               byte_n  = byte_idx + 1'b1;
               state_n = START;
            end else if (left > CNT_W'(1)) begin
               left_n  = left - 1'b1;
               adr_n   = mem_adr_o + 1'b1;
               state_n = READ;
            end else begin
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         mem_adr_o <= '0;
         left      <= '0;
         sh        <= '0;
         byte_idx  <= '0;
         bit_idx   <= '0;
         baud      <= '0;
         tx_o      <= 1'b1;
      end else begin
         state     <= state_n;
         mem_adr_o <= adr_n;
         left      <= left_n;
         sh        <= sh_n;
         byte_idx  <= byte_n;
         bit_idx   <= bit_n;
         baud      <= baud_n;
         tx_o      <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_mem_dump_tx.sv
// tb_uart_mem_dump_tx: scoreboard bench; stimulus queues expected reads/bytes, a UART receiver checks them
module tb_uart_mem_dump_tx;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
   logic [13:0] start_adr = '0;
   logic [14:0] word_cnt = '0;
   logic        mem_rd_o, tx_o, busy_o, done_o;
   logic [13:0] mem_adr_o;
   logic [31:0] mem_dat_i;
   logic [31:0] mem [0:16383];
   logic [7:0]  exp_q [$];
   logic [13:0] adr_q [$];
   int          total = 0, bad = 0;
   int          rx_cnt = 0;
   logic        rx_act = 1'b0;
   logic [7:0]  rx_sh = '0;
   int          lat;

   uart_mem_dump_tx #(.CLKS_PER_BIT(4), .ADDR_W(14), .CNT_W(15)) dut (
      .clock(clock), .reset(reset), .start(start), .start_adr(start_adr), .word_cnt(word_cnt),
      .mem_rd_o(mem_rd_o), .mem_adr_o(mem_adr_o), .mem_dat_i(mem_dat_i),
      .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o));

   always #5 clock = ~clock;

   always @(posedge clock) mem_dat_i <= mem_rd_o ? mem[mem_adr_o] : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && mem_rd_o) begin
         if (adr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read: got adr %0h expected no read", mem_adr_o);
         end else check("read_adr", 32'(mem_adr_o), 32'(adr_q.pop_front()));
      end
   end

   // Receiver: c counts cycles from the first low cycle; bit i centre is c = 6+4i, stop centre c = 38
   always @(negedge clock) begin
      if (reset) rx_act <= 1'b0;
      else if (!rx_act) begin
         if (!tx_o) begin
            rx_act <= 1'b1;
            rx_cnt <= 1;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if (rx_cnt == 2) check("start_bit", 32'(tx_o), 32'd0);
         if (rx_cnt >= 6 && rx_cnt <= 34 && rx_cnt % 4 == 2) rx_sh <= {tx_o, rx_sh[7:1]};
         if (rx_cnt == 38) begin
            check("stop_bit", 32'(tx_o), 32'd1);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h expected none", rx_sh);
            end else check("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
            rx_act <= 1'b0;
         end
      end
   end

   task automatic push_word(input logic [13:0] adr, input logic [31:0] dat);
      mem[adr] = dat;
      adr_q.push_back(adr);
      for (int b = 0; b < 4; b++) exp_q.push_back(dat[8*b +: 8]);
   endtask

   task automatic go(input logic [13:0] adr, input logic [14:0] cnt);
      @(negedge clock);
      start = 1'b1;
      start_adr = adr;
      word_cnt = cnt;
      @(negedge clock);
      start = 1'b0;
      start_adr = ~adr;
      word_cnt = cnt + 15'd5;
      check("busy_set", 32'(busy_o), 32'd1);
   endtask

   task automatic wait_done(input string name, input int exp_cyc, input bit poke, output int first_low);
      int n = 1;
      first_low = -1;
      while (!done_o && n < exp_cyc + 50) begin
         @(negedge clock);
         n++;
         if (first_low < 0 && !tx_o) first_low = n - 1;
         start = poke && (n % 50 == 7);
         start_adr = 14'h2AAA;
         word_cnt = 15'd9;
      end
      start = 1'b0;
      check(name, 32'(n - 1), 32'(exp_cyc));
      @(negedge clock);
      check({name, "_after"}, {30'd0, done_o, busy_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check("idle", {28'd0, tx_o, busy_o, done_o, mem_rd_o}, 32'b1000);
      end

      push_word(14'h10, 32'h4433_2211);
      go(14'h10, 15'd1);
      wait_done("done_cnt1", 162, 1'b0, lat);
      check("tx_latency", 32'(lat), 32'd3);

      push_word(14'h3FFF, 32'h8765_4321);
      push_word(14'h0000, 32'h0F1E_2D3C);
      push_word(14'h0001, 32'hA5C3_E700);
      go(14'h3FFF, 15'd3);
      wait_done("done_wrap", 486, 1'b0, lat);
      check("wrap_latency", 32'(lat), 32'd3);

      go(14'h50, 15'd0);
      wait_done("done_cnt0", 0, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("cnt0_idle", {30'd0, tx_o, mem_rd_o}, 32'b10);
      end

      push_word(14'h20, 32'h1357_9BDF);
      push_word(14'h21, 32'h2468_ACE0);
      go(14'h20, 15'd2);
      wait_done("done_poke", 324, 1'b1, lat);

      push_word(14'h30, 32'h0000_005A);
      go(14'h30, 15'd1);
      repeat (11) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("reset_mid", {29'd0, tx_o, busy_o, done_o}, 32'b100);
      exp_q.delete();
      adr_q.delete();
      @(negedge clock);
      reset = 1'b0;
      push_word(14'h40, 32'hC3A5_0F96);
      go(14'h40, 15'd1);
      wait_done("done_after_reset", 162, 1'b0, lat);
      check("reset_latency", 32'(lat), 32'd3);

      repeat (5) @(negedge clock);
      check("bytes_left", 32'(exp_q.size()), 32'd0);
      check("reads_left", 32'(adr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
